// File: rtl/if_pc_fetch_ctrl_if.sv
// Fetch-stage bundle: hazard controls, redirect bus, ROM port and IF/ID outputs.
// master = pipeline/hazard side driving controls, slave = the fetch controller.
interface if_pc_fetch_ctrl_if;
    logic        stall_i;
    logic        freeze_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] inst_i;
    logic [31:0] pc_o;
    logic        flush_o;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_pc4_o;
    logic [31:0] if_id_inst_o;
    logic        if_id_valid_o;
    logic [31:0] redir_cnt_o;

    modport master (
        output stall_i, freeze_i, redirect_i, redirect_pc_i, inst_i,
        input  pc_o, flush_o, if_id_pc_o, if_id_pc4_o, if_id_inst_o,
               if_id_valid_o, redir_cnt_o
    );

    modport slave (
        input  stall_i, freeze_i, redirect_i, redirect_pc_i, inst_i,
        output pc_o, flush_o, if_id_pc_o, if_id_pc4_o, if_id_inst_o,
               if_id_valid_o, redir_cnt_o
    );
endinterface

// File: rtl/if_pc_fetch_ctrl.sv
// Program counter and IF/ID register owner: applies redirects, stalls and freezes,
// buffers a redirect seen during a freeze and replays it when the freeze lifts.
module if_pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst_n,
    if_pc_fetch_ctrl_if.slave   fif
);

    typedef enum logic [2:0] {
        ACT_STEP,
        ACT_FREEZE,
        ACT_LIVE,
        ACT_PEND,
        ACT_STALL
    } act_e;

    act_e        act;

    logic [31:0] pc_q, pc_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_pc4_q, if_id_pc4_d;
    logic [31:0] if_id_inst_q, if_id_inst_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic        pend_vld_q, pend_vld_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] redir_cnt_q, redir_cnt_d;
    logic        flush;

    function automatic logic [31:0] align_word(input logic [31:0] t);
        return {t[31:2], 2'b00};
    endfunction

    // Priority: freeze > live redirect > pending redirect > stall > sequential step.
    always_comb begin
        act = ACT_STEP;
        if (fif.freeze_i) begin
            act = ACT_FREEZE;
        end else if (fif.redirect_i) begin
            act = ACT_LIVE;
        end else if (pend_vld_q) begin
            act = ACT_PEND;
        end else if (fif.stall_i) begin
            act = ACT_STALL;
        end
    end

    always_comb begin
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_pc4_d   = if_id_pc4_q;
        if_id_inst_d  = if_id_inst_q;
        if_id_valid_d = if_id_valid_q;
        pend_vld_d    = pend_vld_q;
        pend_pc_d     = pend_pc_q;
        redir_cnt_d   = redir_cnt_q;
        flush         = 1'b0;

        unique case (act)
            ACT_FREEZE: begin
                // Latest redirect within one freeze window wins.
                if (fif.redirect_i) begin
                    pend_vld_d = 1'b1;
                    pend_pc_d  = align_word(fif.redirect_pc_i);
                end
            end
            ACT_LIVE, ACT_PEND: begin
                // Bubble keeps the old IF/ID pc/pc4; only inst and valid change.
                pc_d          = (act == ACT_LIVE) ? align_word(fif.redirect_pc_i)
                                                  : pend_pc_q;
                if_id_inst_d  = NOP_INST;
                if_id_valid_d = 1'b0;
                pend_vld_d    = 1'b0;
                redir_cnt_d   = redir_cnt_q + 32'd1;
                flush         = 1'b1;
            end
            ACT_STALL: begin
            end
            default: begin
                pc_d          = pc_q + 32'd4;
                if_id_pc_d    = pc_q;
                if_id_pc4_d   = pc_q + 32'd4;
                if_id_inst_d  = fif.inst_i;
                if_id_valid_d = 1'b1;
            end
        endcase
    end

    // ---- IF -> ID stage boundary ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            if_id_pc_q    <= 32'h0;
            if_id_pc4_q   <= 32'h0;
            if_id_inst_q  <= NOP_INST;
            if_id_valid_q <= 1'b0;
            pend_vld_q    <= 1'b0;
            pend_pc_q     <= 32'h0;
            redir_cnt_q   <= 32'h0;
        end else begin
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_inst_q  <= if_id_inst_d;
            if_id_valid_q <= if_id_valid_d;
            pend_vld_q    <= pend_vld_d;
            pend_pc_q     <= pend_pc_d;
            redir_cnt_q   <= redir_cnt_d;
        end
    end

    assign fif.pc_o          = pc_q;
    assign fif.flush_o       = flush;
    assign fif.if_id_pc_o    = if_id_pc_q;
    assign fif.if_id_pc4_o   = if_id_pc4_q;
    assign fif.if_id_inst_o  = if_id_inst_q;
    assign fif.if_id_valid_o = if_id_valid_q;
    assign fif.redir_cnt_o   = redir_cnt_q;

endmodule

// File: tb/tb_if_pc_fetch_ctrl.sv
// Bench for if_pc_fetch_ctrl: directed scenarios with literal expectations, then
// randomized control traffic compared every cycle against a reference model.
module tb_if_pc_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    if_pc_fetch_ctrl_if fif ();

    if_pc_fetch_ctrl #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fif   (fif)
    );

    always #5 clk = ~clk;

    // Instruction ROM: arbitrary but distinct per address.
    function automatic logic [31:0] rom(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'h5A5A_1234;
    endfunction

    assign fif.inst_i = rom(fif.pc_o);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural fetch state updated once per rising edge.
    logic        m_ready = 1'b0;
    logic [31:0] m_pc, m_id_pc, m_id_pc4, m_id_inst, m_cnt, m_pend_pc;
    logic        m_id_valid, m_pend;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ready = 1'b1;
            m_pc = RESET_PC; m_id_pc = 0; m_id_pc4 = 0; m_id_inst = NOP_INST;
            m_id_valid = 0; m_pend = 0; m_pend_pc = 0; m_cnt = 0;
        end else if (m_ready) begin
            if (fif.freeze_i) begin
                if (fif.redirect_i) begin
                    m_pend = 1;
                    m_pend_pc = fif.redirect_pc_i & 32'hFFFF_FFFC;
                end
            end else if (fif.redirect_i || m_pend) begin
                m_pc = fif.redirect_i ? (fif.redirect_pc_i & 32'hFFFF_FFFC) : m_pend_pc;
                m_id_inst = NOP_INST;
                m_id_valid = 0;
                m_pend = 0;
                m_cnt = m_cnt + 1;
            end else if (!fif.stall_i) begin
                m_id_pc = m_pc;
                m_id_pc4 = m_pc + 4;
                m_id_inst = rom(m_pc);
                m_id_valid = 1;
                m_pc = m_pc + 4;
            end
        end
    end

    // Compare process: mid-cycle, inputs and registered outputs both settled.
    always @(negedge clk) begin
        if (m_ready) begin
            chk("pc_o", fif.pc_o, m_pc);
            chk("if_id_pc_o", fif.if_id_pc_o, m_id_pc);
            chk("if_id_pc4_o", fif.if_id_pc4_o, m_id_pc4);
            chk("if_id_inst_o", fif.if_id_inst_o, m_id_inst);
            chk("if_id_valid_o", {31'h0, fif.if_id_valid_o}, {31'h0, m_id_valid});
            chk("redir_cnt_o", fif.redir_cnt_o, m_cnt);
            if (rst_n)
                chk("flush_o", {31'h0, fif.flush_o},
                    {31'h0, !fif.freeze_i && (fif.redirect_i || m_pend)});
        end
    end

    // Advance one edge; new inputs are applied shortly after it.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input logic st, input logic fr, input logic rd, input logic [31:0] rpc);
        fif.stall_i = st;
        fif.freeze_i = fr;
        fif.redirect_i = rd;
        fif.redirect_pc_i = rpc;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0);
        step(); step();
        rst_n = 1'b1;
        #1;
        // T1: reset values then sequential fetch
        chk("T1 pc reset", fif.pc_o, 32'h0);
        chk("T1 valid reset", {31'h0, fif.if_id_valid_o}, 32'h0);
        chk("T1 inst reset", fif.if_id_inst_o, 32'h13);
        chk("T1 cnt reset", fif.redir_cnt_o, 32'h0);
        step(); #1;
        chk("T1 pc 4", fif.pc_o, 32'h4);
        chk("T1 id pc 0", fif.if_id_pc_o, 32'h0);
        chk("T1 valid 1", {31'h0, fif.if_id_valid_o}, 32'h1);
        chk("T1 inst pc0", fif.if_id_inst_o, 32'h5A5A_1234);
        step(); #1;
        chk("T1 pc 8", fif.pc_o, 32'h8);
        chk("T1 id pc 4", fif.if_id_pc_o, 32'h4);
        step(); step(); #1;
        chk("T2 pc 10", fif.pc_o, 32'h10);
        // T2: live redirect
        set_in(0, 0, 1, 32'h100); #1;
        chk("T2 flush", {31'h0, fif.flush_o}, 32'h1);
        step(); set_in(0, 0, 0, 0); #1;
        chk("T2 pc", fif.pc_o, 32'h100);
        chk("T2 valid", {31'h0, fif.if_id_valid_o}, 32'h0);
        chk("T2 inst", fif.if_id_inst_o, 32'h13);
        chk("T2 cnt", fif.redir_cnt_o, 32'h1);
        step(); #1;
        chk("T2 id pc", fif.if_id_pc_o, 32'h100);
        // T3: stall holds pc
        set_in(0, 0, 1, 32'h20);
        step(); set_in(1, 0, 0, 0);
        step(); step(); #1;
        chk("T3 pc held", fif.pc_o, 32'h20);
        chk("T3 id pc held", fif.if_id_pc_o, 32'h100);
        set_in(0, 0, 0, 0);
        step(); #1;
        chk("T3 pc 24", fif.pc_o, 32'h24);
        // T4: buffered redirect during freeze, unaligned target
        set_in(0, 1, 0, 0);
        step(); set_in(0, 1, 1, 32'h203); #1;
        chk("T4 no flush", {31'h0, fif.flush_o}, 32'h0);
        step(); set_in(0, 1, 0, 0);
        step(); #1;
        chk("T4 pc held", fif.pc_o, 32'h24);
        set_in(0, 0, 0, 0); #1;
        chk("T4 flush", {31'h0, fif.flush_o}, 32'h1);
        step(); #1;
        chk("T4 pc", fif.pc_o, 32'h200);
        chk("T4 cnt", fif.redir_cnt_o, 32'h3);
        chk("T4 valid", {31'h0, fif.if_id_valid_o}, 32'h0);
        step(); #1;
        chk("T4 cnt once", fif.redir_cnt_o, 32'h3);
        // T5: redirect beats stall
        set_in(1, 0, 1, 32'h400);
        step(); set_in(0, 0, 0, 0); #1;
        chk("T5 pc", fif.pc_o, 32'h400);
        chk("T5 valid", {31'h0, fif.if_id_valid_o}, 32'h0);
        // T6: reset discards pending redirect
        set_in(0, 1, 1, 32'h300);
        step(); set_in(0, 1, 0, 0); rst_n = 1'b0;
        step(); rst_n = 1'b1; #1;
        chk("T6 pc reset", fif.pc_o, RESET_PC);
        step(); set_in(0, 0, 0, 0); #1;
        chk("T6 no flush", {31'h0, fif.flush_o}, 32'h0);
        step(); #1;
        chk("T6 pc 4", fif.pc_o, 32'h4);
        chk("T6 cnt", fif.redir_cnt_o, 32'h0);
        set_in(0, 0, 1, 32'hFFFF_FFFE);
        step(); set_in(0, 0, 0, 0); #1;
        chk("T6 pc top", fif.pc_o, 32'hFFFF_FFFC);
        step(); #1;
        chk("T6 pc wrap", fif.pc_o, 32'h0);

        // Randomized traffic, checked every cycle by the compare process.
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15,
                   $urandom_range(0, 99) < 10,
                   ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                               : $urandom);
            rst_n = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1;
        set_in(0, 0, 0, 0);
        step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
